// File: rtl/mips_pkg.sv
// Shared definitions for the MEM/WB writeback slice: load-size codes, FSM states
// and the hard-wired zero register.
package mips_pkg;

  typedef enum logic [1:0] {
    LS_BYTE = 2'b00,
    LS_HALF = 2'b01,
    LS_WORD = 2'b10,
    LS_RSVD = 2'b11
  } load_size_e;

  typedef enum logic {
    IDLE,
    WAIT_LOAD
  } wb_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/writeback_stage_if.sv
// MEM-side handshake, load-return bus and register-file write port of the
// writeback stage; slave is the stage's own view, master the surrounding pipeline.
interface writeback_stage_if;
  import mips_pkg::*;

  logic        mem_valid;
  logic        mem_ready;
  logic        mem_reg_write;
  logic        mem_is_load;
  logic [1:0]  mem_load_size;
  logic        mem_load_sext;
  logic [4:0]  mem_wreg;
  logic [31:0] mem_alu_result;
  logic        load_valid;
  logic [31:0] load_data;
  logic        regWrite;
  logic [4:0]  writeRegister;
  logic [31:0] writeData;

  modport slave (
    input  mem_valid, mem_reg_write, mem_is_load, mem_load_size, mem_load_sext,
           mem_wreg, mem_alu_result, load_valid, load_data,
    output mem_ready, regWrite, writeRegister, writeData
  );

  modport master (
    output mem_valid, mem_reg_write, mem_is_load, mem_load_size, mem_load_sext,
           mem_wreg, mem_alu_result, load_valid, load_data,
    input  mem_ready, regWrite, writeRegister, writeData
  );
endinterface

// File: rtl/load_align.sv
// Big-endian sub-word extraction and sign/zero extension for returning load data,
// plus detection of addresses not naturally aligned to the access size.
module load_align
  import mips_pkg::*;
(
  input  logic [31:0] data_i,
  input  load_size_e  size_i,
  input  logic [1:0]  off_i,
  input  logic        sext_i,
  output logic [31:0] value_o,
  output logic        misaligned_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = '0;
    case (off_i)
      2'd0:    byte_v = data_i[31:24];
      2'd1:    byte_v = data_i[23:16];
      2'd2:    byte_v = data_i[15:8];
      default: byte_v = data_i[7:0];
    endcase
    half_v = off_i[1] ? data_i[15:0] : data_i[31:16];

    value_o      = data_i;
    misaligned_o = 1'b0;
    case (size_i)
      LS_BYTE: value_o = {{24{sext_i & byte_v[7]}}, byte_v};
      LS_HALF: begin
        value_o      = {{16{sext_i & half_v[15]}}, half_v};
        misaligned_o = off_i[0];
      end
      default: misaligned_o = (off_i != 2'd0);
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB stage: latches MEM results, waits (bounded) for load data, and issues
// one registered register-file write pulse per retired instruction.
module writeback_stage
  import mips_pkg::*;
#(
  parameter int unsigned LOAD_TIMEOUT = 16,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  writeback_stage_if.slave     wb,
  output logic                 load_error,
  output logic [CNT_W-1:0]     retire_count
);

  localparam int unsigned TMO_W = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;

  wb_state_e        state_q, state_d;
  logic             regwrite_q, regwrite_d;
  logic [4:0]       wreg_q, wreg_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] retire_q, retire_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             rw_q, rw_d;
  load_size_e       size_q, size_d;
  logic             sext_q, sext_d;
  logic [1:0]       off_q, off_d;

  logic [31:0] aligned;
  logic        misaligned;

  load_align u_align (
    .data_i       (wb.load_data),
    .size_i       (size_q),
    .off_i        (off_q),
    .sext_i       (sext_q),
    .value_o      (aligned),
    .misaligned_o (misaligned)
  );

  always_comb begin
    state_d    = state_q;
    regwrite_d = 1'b0;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    retire_d   = retire_q;
    tmo_d      = tmo_q;
    rw_d       = rw_q;
    size_d     = size_q;
    sext_d     = sext_q;
    off_d      = off_q;
    case (state_q)
      IDLE: begin
        if (wb.mem_valid) begin
          wreg_d = wb.mem_wreg;
          rw_d   = wb.mem_reg_write;
          if (wb.mem_is_load) begin
            size_d  = load_size_e'(wb.mem_load_size);
            sext_d  = wb.mem_load_sext;
            off_d   = wb.mem_alu_result[1:0];
            tmo_d   = '0;
            state_d = WAIT_LOAD;
          end else begin
            wdata_d    = wb.mem_alu_result;
            regwrite_d = wb.mem_reg_write && (wb.mem_wreg != REG_ZERO);
            retire_d   = retire_q + 1'b1;
          end
        end
      end
      WAIT_LOAD: begin
        // load_valid is tested first so data arriving on the timeout edge still commits
        if (wb.load_valid) begin
          state_d  = IDLE;
          retire_d = retire_q + 1'b1;
          if (misaligned) begin
            err_d = 1'b1;
          end else begin
            wdata_d    = aligned;
            regwrite_d = rw_q && (wreg_q != REG_ZERO);
          end
        end else if (tmo_q == TMO_W'(LOAD_TIMEOUT - 1)) begin
          state_d  = IDLE;
          err_d    = 1'b1;
          retire_d = retire_q + 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      retire_q   <= '0;
      tmo_q      <= '0;
      rw_q       <= 1'b0;
      size_q     <= LS_WORD;
      sext_q     <= 1'b0;
      off_q      <= '0;
    end else begin
      state_q    <= state_d;
      regwrite_q <= regwrite_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      retire_q   <= retire_d;
      tmo_q      <= tmo_d;
      rw_q       <= rw_d;
      size_q     <= size_d;
      sext_q     <= sext_d;
      off_q      <= off_d;
    end
  end

  assign wb.mem_ready     = (state_q == IDLE);
  assign wb.regWrite      = regwrite_q;
  assign wb.writeRegister = wreg_q;
  assign wb.writeData     = wdata_q;
  assign load_error       = err_q;
  assign retire_count     = retire_q;

endmodule
